// File: rtl/one_wire_top.sv
// 1-Wire master: reset/presence sequence followed by eight 70 us write slots, sampling the bus in each slot.
// Optional build macro ONE_WIRE_PRESENCE_ABORT_EN ends the transaction after reset recovery when no presence pulse is seen.
module one_wire_top #(
  parameter int CLKS_PER_US = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic       presence_detect,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  inout  wire        one_wire_data
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);

  // Microsecond marks; the reset-sequence marks count from the start of RST_LOW,
  // the slot marks count from the start of each slot.
  localparam logic [9:0] T_RST_LOW  = 10'd480;
  localparam logic [9:0] T_PRES_SMP = 10'd550;
  localparam logic [9:0] T_RST_END  = 10'd960;
  localparam logic [9:0] T_LOW_ONE  = 10'd6;
  localparam logic [9:0] T_LOW_ZERO = 10'd60;
  localparam logic [9:0] T_SLOT_SMP = 10'd15;
  localparam logic [9:0] T_SLOT     = 10'd70;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_PRES_WAIT, S_RST_RECOV, S_SLOT_LOW, S_SLOT_REL, S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PRE_W-1:0] r_pre;
  logic [9:0]       r_us;
  logic [2:0]       r_bit;
  logic [7:0]       r_tx;
  logic             r_presence;
  logic             r_rx_valid;
  logic [7:0]       r_rx_byte;
  logic             w_tick;
  logic [9:0]       w_us_nxt;
  logic [9:0]       w_low_len;
  logic             w_drive_low;
  logic             w_bus_low;

  assign w_tick    = (r_state != S_IDLE) && (r_state != S_FINISH) && (r_pre == PRE_MAX);
  assign w_us_nxt  = r_us + 10'd1;
  assign w_low_len = r_tx[r_bit] ? T_LOW_ONE : T_LOW_ZERO;

  // Open-drain: only ever pull low, otherwise release to the external pull-up.
  assign one_wire_data = w_drive_low ? 1'b0 : 1'bz;
  assign w_bus_low     = (one_wire_data == 1'b0);

  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_FINISH);
  assign presence_detect = r_presence;
  assign rx_valid        = r_rx_valid;
  assign rx_byte         = r_rx_byte;

  always_comb begin
    w_next      = r_state;
    w_drive_low = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && enable) w_next = S_RST_LOW;
      end
      S_RST_LOW: begin
        w_drive_low = 1'b1;
        if (w_tick && (w_us_nxt == T_RST_LOW)) w_next = S_PRES_WAIT;
      end
      S_PRES_WAIT: begin
        if (w_tick && (w_us_nxt == T_PRES_SMP)) w_next = S_RST_RECOV;
      end
      S_RST_RECOV: begin
        if (w_tick && (w_us_nxt == T_RST_END)) begin
`ifdef ONE_WIRE_PRESENCE_ABORT_EN
          w_next = r_presence ? S_SLOT_LOW : S_FINISH;
`else
          w_next = S_SLOT_LOW;
`endif
        end
      end
      S_SLOT_LOW: begin
        w_drive_low = 1'b1;
        if (w_tick && (w_us_nxt == w_low_len)) w_next = S_SLOT_REL;
      end
      S_SLOT_REL: begin
        if (w_tick && (w_us_nxt == T_SLOT)) w_next = (r_bit == 3'd7) ? S_FINISH : S_SLOT_LOW;
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Dropping enable releases the bus at once and abandons the transaction.
    if (!enable && (r_state != S_IDLE)) begin
      w_next      = S_IDLE;
      w_drive_low = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_us       <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_presence <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= 8'h00;
    end else begin
      r_state <= w_next;

      if ((r_state == S_IDLE) || (w_next == S_IDLE) || w_tick) r_pre <= '0;
      else r_pre <= r_pre + 1'b1;

      // The microsecond counter restarts at every slot boundary.
      if (r_state == S_IDLE) r_us <= '0;
      else if (w_tick) r_us <= ((w_next == S_SLOT_LOW) && (r_state != S_SLOT_LOW)) ? 10'd0 : w_us_nxt;

      if ((r_state == S_IDLE) && start && enable) begin
        r_tx       <= tx_byte;
        r_bit      <= '0;
        r_presence <= 1'b0;
        r_rx_valid <= 1'b0;
      end

      if ((r_state == S_PRES_WAIT) && (w_next == S_RST_RECOV)) r_presence <= w_bus_low;

      if (((r_state == S_SLOT_LOW) || (r_state == S_SLOT_REL)) && w_tick && (w_us_nxt == T_SLOT_SMP)) begin
        if (w_bus_low) r_rx_byte[r_bit] <= 1'b0;
        else r_rx_byte[r_bit] <= 1'b1;
      end

      if ((r_state == S_SLOT_REL) && (w_next == S_SLOT_LOW)) r_bit <= r_bit + 3'd1;

      if ((r_state == S_SLOT_REL) && (w_next == S_FINISH)) r_rx_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_one_wire_top.sv
// Bench for one_wire_top: microsecond-level transaction model, bench-side slave, per-cycle compare plus directed literals.
module tb_one_wire_top;

  localparam int N = 2;
`ifdef ONE_WIRE_PRESENCE_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       busy, done, presence_detect, rx_valid;
  logic [7:0] rx_byte;
  wire        one_wire_data;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Slave behaviour requested for the next transaction.
  bit         slave_cfg = 1'b0;
  logic [7:0] mask_cfg  = 8'hFF;

  // Behavioural model: time since the transaction began, counted in clock cycles.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_tx = 8'h00;
  bit         m_slave = 1'b0;
  logic [7:0] m_mask = 8'hFF;
  bit         m_pres = 1'b0;
  bit         m_rx_valid = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;
  logic       w_slave_low;

  one_wire_top #(.CLKS_PER_US(N)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .tx_byte(tx_byte),
    .busy(busy), .done(done), .presence_detect(presence_detect),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .one_wire_data(one_wire_data)
  );

  pullup (one_wire_data);
  assign one_wire_data = w_slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  function automatic int t_end(input bit slv);
    return (ABORT_EN && !slv) ? 960 * N : 1520 * N;
  endfunction

  function automatic bit master_low(input int k, input logic [7:0] tx);
    int s, w;
    if (k < 480 * N) return 1'b1;
    if (k < 960 * N || k >= 1520 * N) return 1'b0;
    s = (k - 960 * N) / (70 * N);
    w = (k - 960 * N) % (70 * N);
    return (w < (tx[s] ? 6 * N : 60 * N));
  endfunction

  // Slave: presence pulse 15..120 us after reset release; pulls low over the sample point of masked-off slots.
  function automatic bit slave_low(input bit act, input int k, input bit slv, input logic [7:0] msk);
    int s, w;
    if (!act) return 1'b0;
    if (slv && k >= 495 * N && k < 600 * N) return 1'b1;
    if (k >= 960 * N && k < 1520 * N) begin
      s = (k - 960 * N) / (70 * N);
      w = (k - 960 * N) % (70 * N);
      if (w >= N && w < 30 * N && !msk[s]) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign w_slave_low = slave_low(m_active, m_k, m_slave, m_mask);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active   <= 1'b0;
      m_k        <= 0;
      m_pres     <= 1'b0;
      m_rx_valid <= 1'b0;
      m_rx_byte  <= 8'h00;
    end else if (!m_active) begin
      if (start && enable) begin
        m_active   <= 1'b1;
        m_k        <= 0;
        m_tx       <= tx_byte;
        m_slave    <= slave_cfg;
        m_mask     <= mask_cfg;
        m_pres     <= 1'b0;
        m_rx_valid <= 1'b0;
      end
    end else if (!enable || m_k == t_end(m_slave)) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == 550 * N) m_pres <= m_slave;
      if (m_k + 1 == 1520 * N) begin
        m_rx_valid <= 1'b1;
        m_rx_byte  <= m_tx & m_mask;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("done", done, m_active && (m_k == t_end(m_slave)));
      chk("bus", one_wire_data,
          !((m_active && enable && master_low(m_k, m_tx)) || w_slave_low));
      chk("presence", presence_detect, m_pres);
      chk("rx_valid", rx_valid, m_rx_valid);
      if (m_rx_valid) chk("rx_byte", rx_byte, m_rx_byte);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] tx);
    tx_byte = tx;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    bit found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else cyc++;
    end
    chk("done_seen", found, 1'b1);
    tick();
  endtask

  initial begin
    int         cyc, n_done, run;
    int         runs[$];
    int         exp_runs[$];
    logic       prev;
    logic [7:0] tx;
    bit         seen_done;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_presence", presence_detect, 1'b0);
    chk("rst_bus", one_wire_data, 1'b1);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // No slave, 0xA5.
    slave_cfg = 1'b0; mask_cfg = 8'hFF;
    pulse_start(8'hA5);
    wait_done(4000, cyc);
    chk("a5_length", cyc, ABORT_EN ? 1920 : 3040);
    chk("a5_rx_valid", rx_valid, ABORT_EN ? 1'b0 : 1'b1);
    chk("a5_rx_byte", rx_byte & {8{!ABORT_EN}}, 8'hA5 & {8{!ABORT_EN}});
    chk("a5_presence", presence_detect, 1'b0);
    repeat (5) tick();

    // Slave presence pulse, 0x3C.
    slave_cfg = 1'b1;
    pulse_start(8'h3C);
    wait_done(4000, cyc);
    chk("3c_length", cyc, 3040);
    chk("3c_presence", presence_detect, 1'b1);
    chk("3c_rx_byte", rx_byte, 8'h3C);
    repeat (5) tick();

    // Bus-low run lengths for 0x01 (slave presence pulse appears as its own run).
    pulse_start(8'h01);
    prev = 1'b1; run = 0; seen_done = 1'b0;
    for (int i = 0; i < 3200 && !seen_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      if (one_wire_data === 1'b0) run++;
      else if (prev === 1'b0) begin runs.push_back(run); run = 0; end
      prev = one_wire_data;
    end
    chk("01_done_seen", seen_done, 1'b1);
    tick();
    exp_runs = '{960, 210, 12, 120, 120, 120, 120, 120, 120, 120};
    chk("01_run_count", runs.size(), exp_runs.size());
    for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
      chk($sformatf("01_run%0d", i), runs[i], exp_runs[i]);
    repeat (5) tick();

    // Start with enable low, then a second start while busy.
    enable = 1'b0;
    pulse_start(8'h77);
    repeat (10) tick();
    chk("en0_busy", busy, 1'b0);
    enable = 1'b1;
    pulse_start(8'h5A);
    repeat (100) tick();
    pulse_start(8'hFF);
    n_done = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    tick();
    chk("one_done_pulse", n_done, 1);
    chk("restart_rx_byte", rx_byte, 8'h5A);

    // Enable dropped 300 us into a transaction.
    pulse_start(8'hC3);
    repeat (300 * N - 1) tick();
    enable = 1'b0;
    @(negedge clk);
    chk("abort_bus_released", one_wire_data, 1'b1);
    tick();
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rx_valid", rx_valid, 1'b0);
    tick();
    enable = 1'b1;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    tick();
    chk("abort_no_done", n_done, 0);

    // Randomized transactions; one is cut short by reset.
    for (int t = 0; t < 5; t++) begin
      tx        = 8'($urandom);
      slave_cfg = 1'($urandom_range(0, 1));
      mask_cfg  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(1, 20)) tick();
      pulse_start(tx);
      if (t == 2) begin
        repeat ($urandom_range(100, 2900)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rx_byte", rx_byte, 8'h00);
        tick();
      end else begin
        wait_done(4000, cyc);
        chk("rnd_presence", presence_detect, slave_cfg);
        if (!ABORT_EN || slave_cfg) chk("rnd_rx_byte", rx_byte, tx & mask_cfg);
      end
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
